// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the instruction memory: word/address widths, the NOP
// encoding and the fixed boot program image. The same package is imported by
// the assembler checker and the fetch-stage model, so it is the single place
// where the boot program lives.
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  localparam int BOOT_WORDS = 8;

  localparam logic [INSTR_W-1:0] BOOT_IMAGE [0:BOOT_WORDS-1] = '{
    16'h1121,
    16'h2232,
    16'h3343,
    16'h4454,
    16'h5565,
    16'h6676,
    16'h7787,
    16'h8898
  };

  // Image word for a full word address; everything past the boot program is NOP.
  function automatic logic [INSTR_W-1:0] boot_word(input logic [ADDR_W-1:0] addr);
    logic [INSTR_W-1:0] word;
    word = NOP;
    if (addr < ADDR_W'(BOOT_WORDS)) begin
      word = BOOT_IMAGE[addr[2:0]];
    end
    return word;
  endfunction

endpackage : mem_pkg

// File: rtl/rom_array.sv
// ---------------------------------------------------------------------------
// rom_array
// Purely combinational constant table of DEPTH instruction words, built from
// the boot image in mem_pkg and padded with NOP up to DEPTH.
//
// Parameters:
//   DEPTH    number of words (power of two)
//   AW       index width, log2(DEPTH)
// Ports:
//   index_i  in   AW        word index into the table
//   word_o   out  INSTR_W   table contents at index_i
// ---------------------------------------------------------------------------
module rom_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0]      index_i,
  output logic [INSTR_W-1:0] word_o
);

  logic [INSTR_W-1:0] table_q [DEPTH];

  // Each entry is a constant, so synthesis folds this into a ROM / logic cone.
  for (genvar g = 0; g < DEPTH; g++) begin : g_fill
    assign table_q[g] = boot_word(ADDR_W'(g));
  end

  assign word_o = table_q[index_i];

endmodule : rom_array

// File: rtl/memory_module.sv
// ---------------------------------------------------------------------------
// memory_module
// Read-only instruction memory for the fetch stage. One word per clock with a
// single registered stage; addresses at or above DEPTH return NOP (no
// aliasing). The output register clears asynchronously while rst is low.
//
// Parameters:
//   DEPTH        number of implemented 16-bit words (power of two, <= 65536)
//   AW           low address bits used as the array index, log2(DEPTH)
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous active-low reset
//   readAddress  in   16  word address to fetch
//   instruction  out  16  registered instruction word
// ---------------------------------------------------------------------------
module memory_module
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   readAddress,
  output logic [INSTR_W-1:0]  instruction
);

  logic [INSTR_W-1:0] rom_word;
  logic               in_range;
  logic [INSTR_W-1:0] instr_d;
  logic [INSTR_W-1:0] instr_q;

  rom_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rom (
    .index_i (readAddress[AW-1:0]),
    .word_o  (rom_word)
  );

  // Any bit above the index field set means the address is past the array.
  // With a full 64K-word array there are no such bits.
  if (AW < ADDR_W) begin : g_range
    assign in_range = ~|readAddress[ADDR_W-1:AW];
  end else begin : g_full
    assign in_range = 1'b1;
  end

  always_comb begin
    instr_d = NOP;
    if (in_range) begin
      instr_d = rom_word;
    end
  end

  // Output register: NOP while in reset, otherwise the word addressed at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= NOP;
    end else begin
      instr_q <= instr_d;
    end
  end

  assign instruction = instr_q;

endmodule : memory_module

// File: tb/tb_memory_module.sv
// ---------------------------------------------------------------------------
// tb_memory_module
// Directed bench for memory_module. Expected words come from a local
// reference table; each fetch pushes its expectation into a queue and the
// value is popped and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_memory_module;

  logic        clk;
  logic        rst;
  logic [15:0] readAddress;
  logic [15:0] instruction;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];

  memory_module #(
    .DEPTH (256),
    .AW    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .readAddress (readAddress),
    .instruction (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference image: boot program at 0..7, NOP everywhere else in 64K.
  function automatic logic [15:0] ref_word(input logic [15:0] a);
    case (a)
      16'd0:   return 16'h1121;
      16'd1:   return 16'h2232;
      16'd2:   return 16'h3343;
      16'd3:   return 16'h4454;
      16'd4:   return 16'h5565;
      16'd5:   return 16'h6676;
      16'd6:   return 16'h7787;
      16'd7:   return 16'h8898;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive an address on the falling edge, then compare one rising edge later.
  task automatic fetch(input string tag, input logic [15:0] addr, input bit release_rst);
    logic [15:0] exp;
    @(negedge clk);
    if (release_rst) rst = 1'b1;
    readAddress = addr;
    exp_q.push_back(ref_word(addr));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected pending entry", tag);
    end else begin
      exp = exp_q.pop_front();
      check(tag, instruction, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    readAddress = 16'h0000;

    // Reset hold, including across the first rising edge at t=5.
    #1;
    check("reset_t1", instruction, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_edge", instruction, 16'h0000);

    // Release at t=10 and fetch sequentially.
    fetch("rel_addr1", 16'd1, 1'b1);
    fetch("seq_addr2", 16'd2, 1'b0);
    fetch("seq_addr3", 16'd3, 1'b0);

    // Unimplemented and out-of-range addresses.
    fetch("nop_addr8",   16'd8,     1'b0);
    fetch("nop_addr255", 16'd255,   1'b0);
    fetch("word0",       16'd0,     1'b0);
    fetch("oor_0100",    16'h0100,  1'b0);
    fetch("oor_0107",    16'h0107,  1'b0);
    fetch("oor_ffff",    16'hFFFF,  1'b0);

    // Mid-run asynchronous reset while fetching address 4.
    fetch("pre_rst_addr4", 16'd4, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_clear", instruction, 16'h0000);
    @(negedge clk);
    readAddress = 16'd3;
    @(posedge clk);
    #1;
    check("rst_hold_addr3", instruction, 16'h0000);
    fetch("post_rst_addr4", 16'd4, 1'b1);

    // Address wiggle during the high phase; only the value at the edge counts.
    fetch("wiggle_base0", 16'd0, 1'b0);
    exp_q.push_back(ref_word(16'd0));
    readAddress = 16'd7;
    #2;
    readAddress = 16'd0;
    #1;
    check("wiggle_hold", instruction, 16'h1121);
    @(posedge clk);
    #1;
    check("wiggle_edge", instruction, exp_q.pop_front());

    // Back-to-back sweep of the boot program.
    for (int i = 0; i < 8; i++) begin
      fetch($sformatf("sweep_%0d", i), 16'(i), 1'b0);
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_memory_module

// File: doc/memory_module.md
# memory_module

Word-addressed, read-only instruction memory for the CPU fetch stage. It holds a fixed boot program image and returns one 16-bit instruction per clock for the 16-bit word address presented by the PC logic. The read is registered. The output is forced to a NOP (16'h0000) while reset is asserted.

## Interface
Parameters:
- DEPTH, 256: number of 16-bit words implemented; must be a power of two, at most 65536.
- AW, log2(DEPTH) = 8: number of low address bits used to index the array.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous assert, active-low (rst = 0 resets).
- readAddress  input  16  word address of the instruction to fetch; consecutive instructions are at consecutive addresses.
- instruction  output  16  registered instruction word.

## Operation
- Storage is a constant image of DEPTH words.
- Words 0–7 are the boot program:
  - 0 = 16'h1121
  - 1 = 16'h2232
  - 2 = 16'h3343
  - 3 = 16'h4454
  - 4 = 16'h5565
  - 5 = 16'h6676
  - 6 = 16'h7787
  - 7 = 16'h8898
- All other words are 16'h0000 (NOP).
- Read: on each rising clk edge with rst = 1, instruction <= image[readAddress[AW-1:0]].
- Out-of-range: if readAddress >= DEPTH (any bit above AW-1 set), instruction <= 16'h0000. There is no aliasing.
- Addressing is in words, not bytes. No alignment check is made.
- There is no write port. Contents never change, including across reset.
- Reset: rst = 0 drives instruction to 16'h0000 immediately, without waiting for a clock edge. It holds that value for as long as rst = 0, regardless of readAddress.
- X/Z on readAddress while out of reset: the output is undefined for that cycle only. There are no sticky effects.

## Timing
- Latency: 1 cycle. The value sampled at rising edge k appears on instruction after edge k and holds until edge k+1.
- Reset value of instruction: 16'h0000.
- Reset release: the first edge with rst = 1 loads the word for the address present at that edge.
- If rst rises coincident with an edge, that edge counts as held in reset: the output stays 16'h0000 and the first load happens on the next edge.
- Reset asserted mid-operation: instruction goes to 16'h0000 asynchronously. Any fetch in flight is discarded.
- Changes to readAddress between edges (for example on the falling edge) do not affect instruction until the next rising edge.
- Throughput: one fetch per cycle, with no stall or handshake.

## Structure
- Shared package mem_pkg holds:
  - INSTR_W = 16 and ADDR_W = 16.
  - NOP = 16'h0000.
  - The boot image constant BOOT_IMAGE [0:7].
  - A function that returns the image word for a given address (NOP beyond 7).
- The package is reused by the assembler checker and the fetch-stage model.
- A single sub-module, rom_array, is natural. It provides a combinational lookup from index to word, built from the package image and filled to DEPTH with NOP.
- memory_module wraps rom_array with the range check and the output register with asynchronous reset.

## Test plan
- Reset hold: clk period 10, rst = 0 for 0–10, readAddress = 0 → instruction = 16'h0000 throughout, including across the edge at t = 5.
- Release and sequential fetch: rst = 1 at t = 10; readAddress steps 1, 2, 3 at t = 10, 20, 30 → instruction = 16'h2232 after t = 15, 16'h3343 after t = 25, 16'h4454 after t = 35.
- Unimplemented and out-of-range addresses:
  - readAddress = 8 → 16'h0000.
  - readAddress = 255 → 16'h0000.
  - readAddress = 16'h0100 → 16'h0000, with no alias to word 0.
  - readAddress = 16'hFFFF → 16'h0000.
- Mid-run async reset: while fetching address 4 (output 16'h5565), drop rst between edges → output becomes 16'h0000 before the next edge. Raise rst → the next edge returns 16'h5565 again, showing contents are unchanged.
- Address change between edges: toggle readAddress 0 → 7 → 0 within one high phase → instruction reflects only the value present at the rising edge (16'h1121).
- Back-to-back sweep: addresses 0..7, one per cycle → outputs match BOOT_IMAGE in order, each with exactly 1-cycle latency.
